// File: rtl/replay_rec_burst_ctrl_pkg.sv
// Shared definitions for the replay record-path burst controller:
// FSM state encoding and AXI response codes.
package replay_rec_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } rec_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_PAGE_BYTES = 4096;

endpackage

// File: rtl/replay_rec_burst_ctrl.sv
// Record-path controller: packs an AXI-Stream input into AXI4 write bursts that
// fill a circular-free memory window, never crossing a 4 KiB page or the buffer end.
//
// state | meaning
// IDLE  | sample base/size, apply restart, plan next burst when input is valid
// ADDR  | present AW for the planned burst
// DATA  | pass stream beats straight through to W, last beat ends the burst
// RESP  | wait for B, commit burst bytes to fullness, record error response
module replay_rec_burst_ctrl
  import replay_rec_burst_ctrl_pkg::*;
#(
  parameter int MEM_DATA_W = 64,
  parameter int MEM_ADDR_W = 16,
  parameter int MAX_BURST  = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MEM_ADDR_W-1:0]     record_base_addr,
  input  logic [MEM_ADDR_W-1:0]     record_buffer_size,
  input  logic                      record_restart,
  output logic [MEM_ADDR_W-1:0]     record_fullness,
  output logic                      err_resp,
  input  logic [MEM_DATA_W-1:0]     i_tdata,
  input  logic                      i_tvalid,
  output logic                      i_tready,
  output logic [MEM_ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [MEM_DATA_W-1:0]     m_axi_wdata,
  output logic [MEM_DATA_W/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready
);

  localparam int BYTES   = MEM_DATA_W / 8;
  localparam int BYTE_SH = $clog2(BYTES);

  localparam logic [MEM_ADDR_W-1:0] WORD_MASK  = ~MEM_ADDR_W'(BYTES - 1);
  localparam logic [MEM_ADDR_W-1:0] PAGE_BYTES = MEM_ADDR_W'(AXI_PAGE_BYTES);
  localparam logic [MEM_ADDR_W-1:0] PAGE_MASK  = MEM_ADDR_W'(AXI_PAGE_BYTES - 1);
  localparam logic [MEM_ADDR_W-1:0] MAX_WORDS  = MEM_ADDR_W'(MAX_BURST);

  rec_state_e              r_state;
  logic [MEM_ADDR_W-1:0]   r_fullness;
  logic                    r_err;
  logic                    r_restart_pend;
  logic [MEM_ADDR_W-1:0]   r_awaddr;
  logic [7:0]              r_awlen;
  logic                    r_awvalid;
  logic                    r_in_data;
  logic                    r_bready;
  logic [7:0]              r_beat;

  logic [MEM_ADDR_W-1:0]   w_base;
  logic [MEM_ADDR_W-1:0]   w_size;
  logic [MEM_ADDR_W-1:0]   w_cur_addr;
  logic [MEM_ADDR_W-1:0]   w_words_left;
  logic [MEM_ADDR_W-1:0]   w_bnd_words;
  logic [MEM_ADDR_W-1:0]   w_burst_words;
  logic [MEM_ADDR_W-1:0]   w_burst_bytes;
  logic                    w_last;
  logic                    w_w_hs;

  assign w_base        = record_base_addr & WORD_MASK;
  assign w_size        = record_buffer_size & WORD_MASK;
  assign w_cur_addr    = w_base + r_fullness;
  // A size shrunk below the committed fullness simply reads as full.
  assign w_words_left  = (w_size > r_fullness) ? ((w_size - r_fullness) >> BYTE_SH) : '0;
  assign w_bnd_words   = (PAGE_BYTES - (w_cur_addr & PAGE_MASK)) >> BYTE_SH;
  assign w_burst_bytes = MEM_ADDR_W'({1'b0, r_awlen} + 9'd1) << BYTE_SH;
  assign w_last        = (r_beat == r_awlen);
  assign w_w_hs        = r_in_data & i_tvalid & m_axi_wready;

  always_comb begin
    w_burst_words = MAX_WORDS;
    if (w_words_left < w_burst_words) w_burst_words = w_words_left;
    if (w_bnd_words < w_burst_words)  w_burst_words = w_bnd_words;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_fullness     <= '0;
      r_err          <= 1'b0;
      r_restart_pend <= 1'b0;
      r_awaddr       <= '0;
      r_awlen        <= '0;
      r_awvalid      <= 1'b0;
      r_in_data      <= 1'b0;
      r_bready       <= 1'b0;
      r_beat         <= '0;
    end else begin
      if (r_state != ST_IDLE && record_restart) r_restart_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (record_restart || r_restart_pend) begin
            r_fullness     <= '0;
            r_err          <= 1'b0;
            r_restart_pend <= 1'b0;
          end else if (i_tvalid && (w_words_left != '0)) begin
            r_awaddr  <= w_cur_addr;
            r_awlen   <= 8'(w_burst_words - MEM_ADDR_W'(1));
            r_awvalid <= 1'b1;
            r_state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_in_data <= 1'b1;
            r_beat    <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_w_hs) begin
            if (w_last) begin
              r_in_data <= 1'b0;
              r_bready  <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid) begin
            r_bready   <= 1'b0;
            r_fullness <= r_fullness + w_burst_bytes;
            if (m_axi_bresp != AXI_RESP_OKAY) r_err <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axi_awaddr    = r_awaddr;
  assign m_axi_awlen     = r_awlen;
  assign m_axi_awvalid   = r_awvalid;
  assign m_axi_wdata     = i_tdata;
  assign m_axi_wstrb     = '1;
  assign m_axi_wvalid    = r_in_data & i_tvalid;
  assign m_axi_wlast     = r_in_data & w_last;
  assign i_tready        = r_in_data & m_axi_wready;
  assign m_axi_bready    = r_bready;
  assign record_fullness = r_fullness;
  assign err_resp        = r_err;

endmodule

// File: tb/tb_replay_rec_burst_ctrl.sv
// Bench for replay_rec_burst_ctrl: scenario table plus hand sequences, with a
// randomized AXI slave / stream source and a burst-planning reference model.
module tb_replay_rec_burst_ctrl;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int MB = 256;
  localparam int BUDGET = 20000;
  localparam logic [63:0] SENT = 64'hDEAD_BEEF_CAFE_F00D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_size = '0;
  logic          record_restart = 1'b0;
  logic [AW-1:0] record_fullness;
  logic          err_resp;
  logic [DW-1:0] i_tdata = '0;
  logic          i_tvalid = 1'b0;
  logic          i_tready;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [7:0]    m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;

  always #5 clk = ~clk;

  replay_rec_burst_ctrl #(.MEM_DATA_W(DW), .MEM_ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .record_base_addr(cfg_base), .record_buffer_size(cfg_size),
    .record_restart(record_restart), .record_fullness(record_fullness),
    .err_resp(err_resp),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stream source, memory image and reference model state.
  logic [63:0] stream [0:1023];
  logic [63:0] mem    [0:8191];
  int s_n = 0, s_idx = 0, stall = 0, err_idx = -1;
  bit tv_hold = 0;
  int exp_full = 0;
  bit rs_pend = 0, burst_open = 0;
  int b_addr = 0, b_len = 0, beat = 0, b_pend = 0;
  int aw_cnt = 0, b_cnt = 0, w_beats = 0, wlast_cnt = 0, tready_cnt = 0;
  int first_addr = 0, first_len = 0, last_awaddr = 0;

  // Slave/source driver: drive on negedge, observe handshakes just before posedge.
  initial begin
    int bw, sw, cur, left, bnd, el;
    forever begin
      @(negedge clk);
      if (!tv_hold) begin
        if (s_idx < s_n && $urandom_range(99) >= stall) begin
          i_tvalid = 1'b1;
          i_tdata  = stream[s_idx];
        end else begin
          i_tvalid = 1'b0;
        end
      end
      m_axi_awready = ($urandom_range(99) >= stall);
      m_axi_wready  = ($urandom_range(99) >= stall);
      m_axi_bvalid  = (b_pend > 0) && ($urandom_range(99) >= stall);
      m_axi_bresp   = (b_cnt == err_idx) ? 2'd2 : 2'd0;
      #4;
      if (rst) begin
        exp_full = 0; rs_pend = 0; burst_open = 0; b_pend = 0; tv_hold = 0;
        aw_cnt = 0; b_cnt = 0; w_beats = 0; wlast_cnt = 0;
      end else begin
        bw = int'(cfg_base & 16'hFFF8);
        sw = int'(cfg_size & 16'hFFF8);
        if (record_restart) begin
          if (!m_axi_awvalid && !burst_open) exp_full = 0;
          else rs_pend = 1;
        end
        if (m_axi_awvalid && m_axi_awready) begin
          cur  = (bw + exp_full) % 65536;
          left = (sw > exp_full) ? (sw - exp_full) / 8 : 0;
          bnd  = (4096 - (cur % 4096)) / 8;
          el = MB;
          if (left < el) el = left;
          if (bnd < el)  el = bnd;
          chk("aw_addr", 64'(m_axi_awaddr), 64'(cur));
          chk("aw_len", 64'(m_axi_awlen), 64'(el - 1));
          if (aw_cnt == 0) begin
            first_addr = int'(m_axi_awaddr);
            first_len  = int'(m_axi_awlen);
          end
          last_awaddr = int'(m_axi_awaddr);
          aw_cnt++;
          b_addr = cur; b_len = el - 1; beat = 0; burst_open = 1;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          chk("w_in_burst", 64'(burst_open && beat <= b_len), 64'd1);
          chk("wlast", 64'(m_axi_wlast), 64'(beat == b_len));
          chk("wstrb", 64'(m_axi_wstrb), 64'hFF);
          mem[(b_addr / 8 + beat) % 8192] = m_axi_wdata;
          if (m_axi_wlast) begin
            wlast_cnt++;
            b_pend++;
          end
          beat++;
          w_beats++;
        end
        if (i_tready) tready_cnt++;
        if (i_tvalid && i_tready) begin
          s_idx++;
          tv_hold = 0;
        end else begin
          tv_hold = i_tvalid;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_pend--;
          b_cnt++;
          exp_full += (b_len + 1) * 8;
          burst_open = 0;
          if (rs_pend) begin
            exp_full = 0;
            rs_pend  = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic tmo(input string nm, input int c);
    chk({"timeout_", nm}, 64'(c >= BUDGET), 64'd0);
  endtask

  task automatic setup(input logic [AW-1:0] b, input logic [AW-1:0] sz,
                       input int n, input int st, input int ei);
    rst = 1'b1;
    tick();
    tick();
    s_n = 0; s_idx = 0;
    cfg_base = b; cfg_size = sz; stall = st; err_idx = ei;
    for (int i = 0; i < 8192; i++) mem[i] = SENT;
    for (int i = 0; i < 1024; i++) stream[i] = {$urandom, $urandom};
    chk("rst_outputs",
        64'({record_fullness, err_resp, m_axi_awvalid, m_axi_wvalid, m_axi_wlast,
             m_axi_bready, i_tready}), 64'd0);
    rst = 1'b0;
    tick();
    s_n = n;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] size;
    int            nwords;
    int            stall;
    logic [AW-1:0] exp_full;
    int            exp_bursts;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_len;
  } scn_t;

  scn_t scn [7];

  initial begin
    int c, tr0, a0, bad, nw, bw;

    //               base      size      n    stall  full      bursts addr      len
    scn[0] = '{16'h0000, 16'h0800, 300,  0, 16'h0800, 1, 16'h0000, 8'd255};
    scn[1] = '{16'h0FC0, 16'h1000, 520,  0, 16'h1000, 3, 16'h0FC0, 8'd7};
    scn[2] = '{16'h3E05, 16'h0403, 136, 75, 16'h0400, 2, 16'h3E00, 8'd63};
    scn[3] = '{16'h8000, 16'h1000, 520, 25, 16'h1000, 2, 16'h8000, 8'd255};
    scn[4] = '{16'h5008, 16'h0028,  10, 50, 16'h0028, 1, 16'h5008, 8'd4};
    scn[5] = '{16'h2000, 16'h0000,   4,  0, 16'h0000, 0, 16'h0000, 8'd0};
    scn[6] = '{16'h0FF8, 16'h0020,   6, 25, 16'h0020, 2, 16'h0FF8, 8'd0};

    for (int si = 0; si < 7; si++) begin
      setup(scn[si].base, scn[si].size, scn[si].nwords, scn[si].stall, -1);
      nw = int'(scn[si].exp_full) / 8;
      c = 0;
      while ((b_cnt < scn[si].exp_bursts || s_idx < nw) && c < BUDGET) begin
        tick();
        c++;
      end
      tmo($sformatf("scn%0d", si), c);
      tick();
      chk($sformatf("scn%0d_fullness", si), 64'(record_fullness), 64'(scn[si].exp_full));
      chk($sformatf("scn%0d_bursts", si), 64'(b_cnt), 64'(scn[si].exp_bursts));
      chk($sformatf("scn%0d_wlast_cnt", si), 64'(wlast_cnt), 64'(scn[si].exp_bursts));
      chk($sformatf("scn%0d_accepted", si), 64'(s_idx), 64'(nw));
      if (scn[si].exp_bursts > 0) begin
        chk($sformatf("scn%0d_first_addr", si), 64'(first_addr), 64'(scn[si].exp_addr));
        chk($sformatf("scn%0d_first_len", si), 64'(first_len), 64'(scn[si].exp_len));
      end
      bw = int'(scn[si].base & 16'hFFF8);
      bad = 0;
      for (int k = 0; k < nw; k++)
        if (mem[(bw / 8 + k) % 8192] !== stream[k]) bad++;
      chk($sformatf("scn%0d_mem_words_bad", si), 64'(bad), 64'd0);
      tr0 = tready_cnt;
      a0  = aw_cnt;
      for (int k = 0; k < 40; k++) tick();
      chk($sformatf("scn%0d_full_tready", si), 64'(tready_cnt - tr0), 64'd0);
      chk($sformatf("scn%0d_full_aw", si), 64'(aw_cnt - a0), 64'd0);
    end

    // Restart during DATA: burst completes, fullness drops to 0, next burst at base.
    setup(16'h0000, 16'h1000, 512, 0, -1);
    c = 0;
    while (w_beats < 10 && c < BUDGET) begin tick(); c++; end
    tmo("rs_data", c);
    record_restart = 1'b1;
    tick();
    record_restart = 1'b0;
    c = 0;
    while (b_cnt < 1 && c < BUDGET) begin tick(); c++; end
    tmo("rs_b1", c);
    tick();
    chk("rs_fullness_zero", 64'(record_fullness), 64'd0);
    c = 0;
    while (b_cnt < 2 && c < BUDGET) begin tick(); c++; end
    tmo("rs_b2", c);
    tick();
    chk("rs_second_awaddr", 64'(last_awaddr), 64'd0);
    chk("rs_fullness_end", 64'(record_fullness), 64'h800);

    // Error response on the second burst is sticky until restart.
    setup(16'h0000, 16'h1800, 768, 0, 1);
    c = 0;
    while (b_cnt < 1 && c < BUDGET) begin tick(); c++; end
    tmo("err_b1", c);
    chk("err_after_b1", 64'(err_resp), 64'd0);
    c = 0;
    while (b_cnt < 2 && c < BUDGET) begin tick(); c++; end
    tmo("err_b2", c);
    chk("err_after_b2", 64'(err_resp), 64'd1);
    c = 0;
    while (b_cnt < 3 && c < BUDGET) begin tick(); c++; end
    tmo("err_b3", c);
    chk("err_after_b3", 64'(err_resp), 64'd1);
    chk("err_fullness", 64'(record_fullness), 64'h1800);
    tick();
    record_restart = 1'b1;
    tick();
    record_restart = 1'b0;
    chk("err_cleared", 64'(err_resp), 64'd0);
    chk("err_restart_fullness", 64'(record_fullness), 64'd0);

    // Reset in the middle of the second burst.
    setup(16'h0000, 16'h1000, 512, 0, -1);
    c = 0;
    while ((b_cnt < 1 || w_beats < 276) && c < BUDGET) begin tick(); c++; end
    tmo("rst_mid", c);
    chk("pre_rst_fullness", 64'(record_fullness), 64'h800);
    rst = 1'b1;
    tick();
    chk("rst_mid_fullness", 64'(record_fullness), 64'd0);
    chk("rst_mid_outs",
        64'({m_axi_wvalid, i_tready, m_axi_awvalid, m_axi_bready, m_axi_wlast}), 64'd0);
    rst = 1'b0;
    c = 0;
    while (aw_cnt < 1 && c < BUDGET) begin tick(); c++; end
    tmo("rst_restart_aw", c);
    chk("rst_next_awaddr", 64'(last_awaddr), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
